pe_pos_feeder: RTL and testbench

PE_POS_FEEDER -- requirements
Module: pe_pos_feeder

---
 rtl/pe_pos_feeder.sv | 144 ++++++++++++++
 tb/tb_pe_pos_feeder.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_pos_feeder.sv
// Position feeder for one PE: streams home offsets from the home cache, then neighbor
// positions, then drains. Optional stall counter enabled by `define PE_FEEDER_STALL_CNT_EN.
module pe_pos_feeder #(
  parameter int HOME_ADDR_WIDTH         = 8,
  parameter int STALL_CNT_WIDTH         = 32,
  parameter int OFFSET_PKT_STRUCT_WIDTH = 48,
  parameter int POS_PKT_STRUCT_WIDTH    = 96,
  parameter int NODE_ID_WIDTH           = 8
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic [HOME_ADDR_WIDTH-1:0]         home_count,
  output logic                               home_rd_en,
  output logic [HOME_ADDR_WIDTH-1:0]         home_rd_addr,
  input  logic [OFFSET_PKT_STRUCT_WIDTH-1:0] home_rd_data,
  input  logic [POS_PKT_STRUCT_WIDTH-1:0]    nb_in_data,
  input  logic [NODE_ID_WIDTH-1:0]           nb_in_node_id,
  input  logic                               nb_in_valid,
  input  logic                               nb_in_last,
  output logic                               nb_in_ready,
  input  logic                               disp_back_pressure,
  input  logic                               disp_buf_empty,
  output logic [OFFSET_PKT_STRUCT_WIDTH-1:0] home_offset,
  output logic                               home_offset_valid,
  output logic [POS_PKT_STRUCT_WIDTH-1:0]    nb_pos,
  output logic [NODE_ID_WIDTH-1:0]           pos_node_id,
  output logic                               nb_pos_valid,
  output logic                               pos_spinning,
  output logic                               busy,
  output logic                               done,
  output logic [STALL_CNT_WIDTH-1:0]         stall_cycles,
  output logic [2:0]                         dbg_state
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HOME_LOAD = 3'd1,
    NB_STREAM = 3'd2,
    DRAIN     = 3'd3,
    DONE      = 3'd4
  } state_t;

  localparam logic [HOME_ADDR_WIDTH-1:0] ADDR_ONE = 1;

  state_t                     state, state_nxt;
  logic [HOME_ADDR_WIDTH-1:0] count_q;
  logic [HOME_ADDR_WIDTH-1:0] addr_q;
  logic                       start_acc;
  logic                       nb_fire;

  // Neighbor handshake: a packet transfers on a rising edge where nb_in_valid and
  // nb_in_ready are both high; ready never depends on valid.
  assign start_acc    = start && (state == IDLE);
  assign nb_fire      = nb_in_valid && nb_in_ready;
  assign home_rd_addr = addr_q;
  assign dbg_state    = state;

  // Cache data arrives in the cycle after the read, so it is forwarded directly.
  assign home_offset  = home_offset_valid ? home_rd_data : '0;

  always_comb begin
    state_nxt    = state;
    home_rd_en   = 1'b0;
    nb_in_ready  = 1'b0;
    pos_spinning = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start)
          state_nxt = (home_count == '0) ? NB_STREAM : HOME_LOAD;
      end
      HOME_LOAD: begin
        home_rd_en = !disp_back_pressure;
        if (!disp_back_pressure && (addr_q == count_q - ADDR_ONE))
          state_nxt = NB_STREAM;
      end
      NB_STREAM: begin
        nb_in_ready  = !disp_back_pressure;
        pos_spinning = 1'b1;
        if (nb_in_valid && !disp_back_pressure && nb_in_last)
          state_nxt = DRAIN;
      end
      DRAIN: begin
        pos_spinning = 1'b1;
        if (disp_buf_empty && !home_offset_valid && !nb_pos_valid)
          state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      count_q           <= '0;
      addr_q            <= '0;
      home_offset_valid <= 1'b0;
      nb_pos_valid      <= 1'b0;
      nb_pos            <= '0;
      pos_node_id       <= '0;
    end else begin
      state             <= state_nxt;
      home_offset_valid <= home_rd_en;
      nb_pos_valid      <= nb_fire;
      if (start_acc) begin
        count_q <= home_count;
        addr_q  <= '0;
      end else if (home_rd_en) begin
        addr_q  <= addr_q + ADDR_ONE;
      end
      if (nb_fire) begin
        nb_pos      <= nb_in_data;
        pos_node_id <= nb_in_node_id;
      end
    end
  end

`ifdef PE_FEEDER_STALL_CNT_EN
  localparam logic [STALL_CNT_WIDTH-1:0] STALL_ONE = 1;
  logic [STALL_CNT_WIDTH-1:0] stall_q;

  // Saturating count of cycles the dispatcher held off an active load/stream phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      stall_q <= '0;
    else if (start_acc)
      stall_q <= '0;
    else if ((state == HOME_LOAD || state == NB_STREAM) && disp_back_pressure && !(&stall_q))
      stall_q <= stall_q + STALL_ONE;
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pe_pos_feeder.sv
// Self-checking bench for pe_pos_feeder: cache model, packet driver, and scoreboard
// queues for home offsets and neighbor positions.
module tb_pe_pos_feeder;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [7:0]   home_count = '0;
  logic         home_rd_en;
  logic [7:0]   home_rd_addr;
  logic [47:0]  home_rd_data = '0;
  logic [95:0]  nb_in_data = '0;
  logic [7:0]   nb_in_node_id = '0;
  logic         nb_in_valid = 1'b0;
  logic         nb_in_last = 1'b0;
  logic         nb_in_ready;
  logic         disp_back_pressure = 1'b0;
  logic         disp_buf_empty = 1'b0;
  logic [47:0]  home_offset;
  logic         home_offset_valid;
  logic [95:0]  nb_pos;
  logic [7:0]   pos_node_id;
  logic         nb_pos_valid;
  logic         pos_spinning;
  logic         busy;
  logic         done;
  logic [31:0]  stall_cycles;
  logic [2:0]   dbg_state;

  int total = 0;
  int bad = 0;
  int rd_cnt = 0, off_cnt = 0, nb_cnt = 0, done_cnt = 0;
  int exp_reads_left = 0;
  logic [7:0]   exp_addr = '0;
  logic         prev_rd = 1'b0, prev_xfer = 1'b0;
  logic         bp_phase = 1'b1;
  logic [47:0]  exp_home_q[$];
  logic [103:0] exp_nb_q[$];

  pe_pos_feeder dut (
    .clk(clk), .rst(rst), .start(start), .home_count(home_count),
    .home_rd_en(home_rd_en), .home_rd_addr(home_rd_addr), .home_rd_data(home_rd_data),
    .nb_in_data(nb_in_data), .nb_in_node_id(nb_in_node_id), .nb_in_valid(nb_in_valid),
    .nb_in_last(nb_in_last), .nb_in_ready(nb_in_ready),
    .disp_back_pressure(disp_back_pressure), .disp_buf_empty(disp_buf_empty),
    .home_offset(home_offset), .home_offset_valid(home_offset_valid),
    .nb_pos(nb_pos), .pos_node_id(pos_node_id), .nb_pos_valid(nb_pos_valid),
    .pos_spinning(pos_spinning), .busy(busy), .done(done),
    .stall_cycles(stall_cycles), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [47:0] mem_f(input logic [7:0] a);
    return {a, 8'h5A, a ^ 8'hFF, 24'h123400 + {16'h0, a}};
  endfunction

  // home cache: registered read, one cycle latency
  always @(posedge clk)
    home_rd_data <= home_rd_en ? mem_f(home_rd_addr) : '0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // monitor / scoreboard, sampled on the falling edge
  always @(negedge clk) begin
    if (rst) begin
      prev_rd   = 1'b0;
      prev_xfer = 1'b0;
    end else begin
      check("off_vld_timing", home_offset_valid, prev_rd);
      check("nb_vld_timing", nb_pos_valid, prev_xfer);
      if (home_rd_en) begin
        rd_cnt++;
        check("ready_in_load", nb_in_ready, 1'b0);
        if (exp_reads_left == 0) check("rd_extra", 1'b1, 1'b0);
        else begin
          check("rd_addr", home_rd_addr, exp_addr);
          exp_addr++;
          exp_reads_left--;
        end
      end
      if (home_offset_valid) begin
        off_cnt++;
        if (exp_home_q.size() == 0) check("home_extra", 1'b1, 1'b0);
        else check("home_off", home_offset, exp_home_q.pop_front());
      end
      if (nb_pos_valid) begin
        nb_cnt++;
        if (exp_nb_q.size() == 0) check("nb_extra", 1'b1, 1'b0);
        else check("nb_pos", {pos_node_id, nb_pos}, exp_nb_q.pop_front());
      end
      if (nb_in_valid && nb_in_ready) exp_nb_q.push_back({nb_in_node_id, nb_in_data});
      if (done) done_cnt++;
      prev_rd   = home_rd_en;
      prev_xfer = nb_in_valid && nb_in_ready;
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_round(input logic [7:0] n);
    exp_addr       = '0;
    exp_reads_left = n;
    for (int i = 0; i < n; i++) exp_home_q.push_back(mem_f(i[7:0]));
    start      = 1'b1;
    home_count = n;
    #1;
    check("spin_pre_start", pos_spinning, 1'b0);
    tick();
    start      = 1'b0;
    home_count = 8'hEE;
    check("busy_after_start", busy, 1'b1);
    if (n == 0) check("spin_after_start", pos_spinning, 1'b1);
  endtask

  task automatic send_pkts(input int n, input int mode, input bit with_last);
    for (int i = 0; i < n; i++) begin
      int budget;
      bit sent;
      nb_in_valid   = 1'b1;
      nb_in_data    = {$urandom, $urandom, $urandom};
      nb_in_node_id = 8'($urandom_range(0, 255));
      nb_in_last    = with_last && (i == n - 1);
      sent   = 1'b0;
      budget = 0;
      while (!sent && budget < 200) begin
        if (mode == 1) begin
          disp_back_pressure = bp_phase;
          bp_phase = !bp_phase;
        end else if (mode == 2) begin
          disp_back_pressure = ($urandom_range(0, 3) == 0);
        end
        #1;
        if (mode == 1) check("nb_ready_toggle", nb_in_ready, !disp_back_pressure);
        sent = nb_in_ready;
        tick();
        budget++;
      end
      if (!sent) check("nb_timeout", 1'b0, 1'b1);
    end
    nb_in_valid        = 1'b0;
    nb_in_last         = 1'b0;
    disp_back_pressure = 1'b0;
  endtask

  task automatic finish_round(input bit start_in_drain, input bit start_in_done);
    int d0;
    d0 = done_cnt;
    check("spin_drain", pos_spinning, 1'b1);
    check("ready_drain", nb_in_ready, 1'b0);
    if (start_in_drain) begin
      start = 1'b1;
      home_count = 8'd7;
    end
    tick();
    start = 1'b0;
    tick();
    check("no_done_not_empty", done_cnt, d0);
    disp_buf_empty = 1'b1;
    tick();
    if (start_in_done) begin
      start = 1'b1;
      home_count = 8'd9;
    end
    @(negedge clk);
    check("done_latency", done, 1'b1);
    @(posedge clk);
    #1;
    start = 1'b0;
    disp_buf_empty = 1'b0;
    check("idle_after_done", busy, 1'b0);
    tick();
    check("idle_stays", busy, 1'b0);
    check("single_done", done_cnt, d0 + 1);
  endtask

  task automatic nominal_round(input logic [7:0] n, input int npk, input int mode);
    int r0, o0, b0;
    r0 = rd_cnt; o0 = off_cnt; b0 = nb_cnt;
    start_round(n);
    send_pkts(npk, mode, 1'b1);
    finish_round(1'b0, 1'b0);
    check("home_rd_total", rd_cnt - r0, n);
    check("home_off_total", off_cnt - o0, n);
    check("nb_total", nb_cnt - b0, npk);
  endtask

  initial begin
    int r0, o0, b0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_ready", nb_in_ready, 1'b0);
    check("rst_rd_en", home_rd_en, 1'b0);
    check("rst_outs", {home_offset_valid, nb_pos_valid, pos_spinning, done}, 4'b0);
    check("rst_stall", stall_cycles, 32'd0);
    rst = 1'b0;
    tick();

    // nominal: 4 home reads back to back, 3 neighbor packets
    r0 = rd_cnt; o0 = off_cnt; b0 = nb_cnt;
    start_round(8'd4);
    repeat (4) tick();
    check("home_consecutive", rd_cnt - r0, 4);
    send_pkts(3, 0, 1'b1);
    finish_round(1'b0, 1'b0);
    check("nom_off_total", off_cnt - o0, 4);
    check("nom_nb_total", nb_cnt - b0, 3);
    check("nom_stall", stall_cycles, 32'd0);

    // home back pressure after the 2nd read
    r0 = rd_cnt; o0 = off_cnt;
    start_round(8'd4);
    tick();
    tick();
    disp_back_pressure = 1'b1;
    check("bp_two_reads", rd_cnt - r0, 2);
    repeat (3) tick();
    disp_back_pressure = 1'b0;
    check("bp_paused", rd_cnt - r0, 2);
    repeat (2) tick();
    check("bp_resumed", rd_cnt - r0, 4);
    send_pkts(2, 0, 1'b1);
    finish_round(1'b0, 1'b0);
    check("bp_off_total", off_cnt - o0, 4);
`ifdef PE_FEEDER_STALL_CNT_EN
    check("bp_stall", stall_cycles, 32'd3);
`else
    check("bp_stall", stall_cycles, 32'd0);
`endif

    // neighbor stall with toggling back pressure
    b0 = nb_cnt;
    bp_phase = 1'b1;
    start_round(8'd0);
    send_pkts(6, 1, 1'b1);
    finish_round(1'b0, 1'b0);
    check("toggle_nb_total", nb_cnt - b0, 6);
`ifdef PE_FEEDER_STALL_CNT_EN
    check("toggle_stall_nz", stall_cycles != 0, 1'b1);
`else
    check("toggle_stall", stall_cycles, 32'd0);
`endif

    // home_count 0; nb_in_last without valid must not end the stream
    r0 = rd_cnt;
    start_round(8'd0);
    nb_in_last = 1'b1;
    repeat (2) tick();
    nb_in_last = 1'b0;
    #1;
    check("last_no_hs", nb_in_ready, 1'b1);
    check("zero_no_reads", rd_cnt - r0, 0);
    send_pkts(2, 0, 1'b1);
    finish_round(1'b0, 1'b0);
    check("zero_stall_cleared", stall_cycles, 32'd0);

    // reset mid-stream after 2 of 5 packets
    start_round(8'd1);
    send_pkts(2, 0, 1'b0);
    nb_in_valid = 1'b1;
    rst = 1'b1;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_valids", {nb_pos_valid, home_offset_valid, nb_in_ready, pos_spinning, done}, 5'b0);
    check("mid_rst_data", {nb_pos, pos_node_id, home_offset}, 152'd0);
    check("mid_rst_stall", stall_cycles, 32'd0);
    nb_in_valid = 1'b0;
    exp_nb_q.delete();
    exp_home_q.delete();
    exp_reads_left = 0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    nominal_round(8'd3, 3, 0);

    // starts during DRAIN and DONE are ignored
    r0 = rd_cnt;
    start_round(8'd3);
    send_pkts(2, 0, 1'b1);
    finish_round(1'b1, 1'b1);
    repeat (3) tick();
    check("ignored_starts_reads", rd_cnt - r0, 3);
    check("ignored_starts_busy", busy, 1'b0);

    // randomized back pressure round
    nominal_round(8'($urandom_range(1, 6)), 4, 2);

    check("home_q_empty", exp_home_q.size(), 0);
    check("nb_q_empty", exp_nb_q.size(), 0);
    check("reads_left", exp_reads_left, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
